// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
//
// Upstream stage of the SPI facade. It pops 16-bit host commands
// {opcode[15:8], arg[7:0]}, runs them one at a time and collects the bytes
// the facade receives into a small response FIFO for the host.
//
//   opcode 0x00  transfer byte arg through the facade (go / busy / data_ready)
//   opcode 0x01  assert chip select
//   opcode 0x02  deassert chip select
//   opcode 0x03  wait arg*DELAY_UNIT clocks (arg==0 is a no-op)
//   other        dropped, sets the sticky err_opcode flag
//
// Parameters
//   RESP_DEPTH  response FIFO depth (power of two, >= 2)
//   DELAY_UNIT  clocks per delay count (>= 1)
//   TIMEOUT     watchdog limit in clocks for a transfer (watchdog builds only)
//
// Build option
//   SPI_SEQ_TIMEOUT_EN  when defined, a watchdog aborts a transfer that has
//                       spent TIMEOUT clocks in XFER_GO/XFER_WAIT, sets the
//                       sticky err_timeout flag and pushes nothing. When not
//                       defined, err_timeout is tied low and transfers wait
//                       for the facade indefinitely.
//
// Ports
//   clock           system clock
//   reset           synchronous, active-low reset
//   cmd_data        command word {opcode, arg}
//   cmd_valid       command word valid
//   cmd_ready       command accepted when cmd_valid & cmd_ready
//   resp_data       FIFO head byte, valid when resp_valid
//   resp_valid      response FIFO not empty
//   resp_ready      pops the head when resp_valid & resp_ready
//   spi_in_data     byte handed to the facade
//   spi_go          facade start request
//   spi_busy        facade transmitting
//   spi_data_ready  facade one-cycle completion pulse
//   spi_out_data    byte received by the facade, valid with spi_data_ready
//   cs_active       chip select asserted
//   err_opcode      sticky: unknown opcode seen
//   err_timeout     sticky: transfer watchdog expired
// -----------------------------------------------------------------------------
module spi_cmd_sequencer #(
  parameter int unsigned RESP_DEPTH = 16,
  parameter int unsigned DELAY_UNIT = 32,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  resp_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  spi_in_data,
  output logic        spi_go,
  input  logic        spi_busy,
  input  logic        spi_data_ready,
  input  logic [7:0]  spi_out_data,
  output logic        cs_active,
  output logic        err_opcode,
  output logic        err_timeout
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  // Wide enough for the largest load, 255 * DELAY_UNIT.
  localparam int unsigned DLY_W = $clog2(255 * DELAY_UNIT + 1);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RESP_DEPTH);

  localparam logic [7:0] OP_XFER   = 8'h00;
  localparam logic [7:0] OP_CS_ON  = 8'h01;
  localparam logic [7:0] OP_CS_OFF = 8'h02;
  localparam logic [7:0] OP_DELAY  = 8'h03;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_XFER_GO   = 2'd1,
    S_XFER_WAIT = 2'd2,
    S_DELAY     = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic               cs_q, cs_d;
  logic               err_op_q, err_op_d;
  logic [7:0]         in_data_q, in_data_d;
  logic [DLY_W-1:0]   dly_q, dly_d;

  logic [7:0]         mem [RESP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_inc;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         head_q, head_d;

  logic               push_req;
  logic               push_en;
  logic               pop_en;
  logic               timeout_hit;

  logic [7:0]         cmd_op;
  logic [7:0]         cmd_arg;

  assign cmd_op  = cmd_data[15:8];
  assign cmd_arg = cmd_data[7:0];

  // ---------------------------------------------------------------------------
  // Optional transfer watchdog
  // ---------------------------------------------------------------------------
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_to_q, err_to_d;
  logic             in_xfer;

  assign in_xfer = (state_q == S_XFER_GO) || (state_q == S_XFER_WAIT);

  // Fires on the TIMEOUT-th clock spent in the transfer states. A completion
  // pulse arriving on that very clock wins and the byte is kept.
  assign timeout_hit = in_xfer && (tmr_q == TMR_W'(TIMEOUT - 1)) &&
                       !((state_q == S_XFER_WAIT) && spi_data_ready);

  always_comb begin
    tmr_d    = tmr_q;
    err_to_d = err_to_q;
    // Held at zero while idle, so every transfer starts from a clean count.
    if (state_q == S_IDLE) begin
      tmr_d = '0;
    end else if (in_xfer) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
    if (timeout_hit) begin
      err_to_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tmr_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      tmr_q    <= tmr_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout = err_to_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Command FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    err_op_d  = err_op_q;
    in_data_d = in_data_q;
    dly_d     = dly_q;
    cmd_ready = 1'b0;
    spi_go    = 1'b0;
    push_req  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Refusing every command while full guarantees room for the byte of
        // any transfer accepted here. Gated by reset so nothing is offered
        // while the block is being held in reset.
        cmd_ready = reset && (count_q != FULL_COUNT);
        if (cmd_valid && cmd_ready) begin
          case (cmd_op)
            OP_XFER: begin
              in_data_d = cmd_arg;
              state_d   = S_XFER_GO;
            end
            OP_CS_ON:  cs_d = 1'b1;
            OP_CS_OFF: cs_d = 1'b0;
            OP_DELAY: begin
              if (cmd_arg != 8'h00) begin
                dly_d   = DLY_W'(cmd_arg) * DLY_W'(DELAY_UNIT);
                state_d = S_DELAY;
              end
            end
            default: err_op_d = 1'b1;
          endcase
        end
      end

      S_XFER_GO: begin
        // go is held until the facade reports busy; it drops in the same
        // cycle the FSM moves on, so the facade sees exactly one request.
        if (timeout_hit) begin
          state_d = S_IDLE;
        end else if (spi_busy) begin
          state_d = S_XFER_WAIT;
        end else begin
          spi_go = 1'b1;
        end
      end

      S_XFER_WAIT: begin
        if (spi_data_ready) begin
          push_req = 1'b1;
          state_d  = S_IDLE;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end

      S_DELAY: begin
        // Entered with arg*DELAY_UNIT; leaving on the cycle the count is 1
        // gives exactly that many clocks in this state.
        dly_d = dly_q - DLY_W'(1);
        if (dly_q == DLY_W'(1)) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cs_q      <= 1'b0;
      err_op_q  <= 1'b0;
      in_data_q <= 8'h00;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      err_op_q  <= err_op_d;
      in_data_q <= in_data_d;
      dly_q     <= dly_d;
    end
  end

  assign cs_active   = cs_q;
  assign err_opcode  = err_op_q;
  assign spi_in_data = in_data_q;

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  assign pop_en     = resp_ready && (count_q != '0);
  assign push_en    = reset && push_req && ((count_q != FULL_COUNT) || pop_en);
  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // The head byte lives in its own register so resp_data is a clean flop
  // output. It takes the incoming byte when that byte becomes the new head
  // (FIFO empty, or single entry being popped in the same cycle); otherwise
  // a pop advances it to the next stored entry.
  always_comb begin
    head_d = head_q;
    if (push_en && ((count_q == '0) || (pop_en && (count_q == CNT_W'(1))))) begin
      head_d = spi_out_data;
    end else if (pop_en && (count_q > CNT_W'(1))) begin
      head_d = mem[rd_ptr_inc];
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) begin
      mem[wr_ptr_q] <= spi_out_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 8'h00;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_inc;
      end
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign resp_valid = (count_q != '0);
  assign resp_data  = head_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_sequencer
//
// Directed bench for spi_cmd_sequencer. A small facade model answers each go
// request: it goes busy for four clocks, then pulses data_ready with the sent
// byte XOR facade_xor, so every expected response byte is known up front.
// -----------------------------------------------------------------------------
module tb_spi_cmd_sequencer;

  localparam int DEPTH = 16;
  localparam int UNIT  = 32;
  localparam int TO    = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cmd_data = 16'h0000;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  spi_in_data;
  logic        spi_go;
  logic        spi_busy;
  logic        spi_data_ready;
  logic [7:0]  spi_out_data;
  logic        cs_active;
  logic        err_opcode;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  logic [7:0] facade_xor = 8'hFF;
  bit         facade_en  = 1'b1;
  int         go_count   = 0;
  int         fcnt       = 0;
  logic [7:0] f_rx       = 8'h00;

  spi_cmd_sequencer #(
    .RESP_DEPTH (DEPTH),
    .DELAY_UNIT (UNIT),
    .TIMEOUT    (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset_n),
    .cmd_data       (cmd_data),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .resp_data      (resp_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .spi_in_data    (spi_in_data),
    .spi_go         (spi_go),
    .spi_busy       (spi_busy),
    .spi_data_ready (spi_data_ready),
    .spi_out_data   (spi_out_data),
    .cs_active      (cs_active),
    .err_opcode     (err_opcode),
    .err_timeout    (err_timeout)
  );

  always #5 clock = ~clock;

  // Facade model: busy for four clocks after a go, then a one-cycle done pulse.
  always @(posedge clock) begin
    if (!reset_n) begin
      spi_busy       <= 1'b0;
      spi_data_ready <= 1'b0;
      spi_out_data   <= 8'h00;
      fcnt           <= 0;
    end else begin
      spi_data_ready <= 1'b0;
      if (spi_busy) begin
        if (fcnt == 1) begin
          spi_busy       <= 1'b0;
          spi_data_ready <= 1'b1;
          spi_out_data   <= f_rx;
        end
        fcnt <= fcnt - 1;
      end else if (spi_go && facade_en) begin
        spi_busy <= 1'b1;
        fcnt     <= 4;
        f_rx     <= spi_in_data ^ facade_xor;
      end
    end
  end

  always @(posedge clock) begin
    if (spi_go) go_count <= go_count + 1;
  end

  // Returns on the falling edge right after the accepting clock edge.
  task automatic send_cmd(input logic [15:0] c);
    int n;
    n = 0;
    @(negedge clock);
    cmd_data  = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_cmd: cmd %h never accepted, cmd_ready=%b required 1", c, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    $display("cmd %h accepted at %0t", c, $time);
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: resp_valid=%b never rose, required 1", tag, resp_valid);
    end
  endtask

  task automatic pop_one();
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({cmd_ready, spi_go, cs_active, resp_valid, err_opcode, err_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: {ready,go,cs,valid,eop,eto}=%b required 000000",
               {cmd_ready, spi_go, cs_active, resp_valid, err_opcode, err_timeout});
    end
    checks++;
    if ({spi_in_data, resp_data} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: in_data=%h resp_data=%h required 00 00", spi_in_data, resp_data);
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
    $display("reset released at %0t", $time);
  endtask

  task automatic test_cs_xfer();
    int g0;
    facade_xor = 8'h99;                 // 0xA5 ^ 0x99 = 0x3C
    g0 = go_count;
    send_cmd(16'h0100);
    checks++;
    if (cs_active !== 1'b1) begin
      errors++;
      $display("FAIL cs_assert: cs_active=%b required 1", cs_active);
    end
    send_cmd(16'h00A5);
    checks++;
    if (spi_in_data !== 8'hA5) begin
      errors++;
      $display("FAIL xfer_in_data: spi_in_data=%h required a5", spi_in_data);
    end
    checks++;
    if (spi_go !== 1'b1) begin
      errors++;
      $display("FAIL xfer_go: spi_go=%b required 1", spi_go);
    end
    wait_resp("xfer_resp_wait");
    checks++;
    if (resp_data !== 8'h3C) begin
      errors++;
      $display("FAIL xfer_resp: resp_data=%h required 3c", resp_data);
    end
    checks++;
    if (go_count - g0 !== 1) begin
      errors++;
      $display("FAIL xfer_go_count: go cycles=%0d required 1", go_count - g0);
    end
    checks++;
    if (cs_active !== 1'b1) begin
      errors++;
      $display("FAIL cs_hold: cs_active=%b required 1", cs_active);
    end
    send_cmd(16'h0200);
    checks++;
    if (cs_active !== 1'b0) begin
      errors++;
      $display("FAIL cs_deassert: cs_active=%b required 0", cs_active);
    end
    pop_one();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL xfer_pop: resp_valid=%b required 0", resp_valid);
    end
    facade_xor = 8'hFF;
  endtask

  task automatic test_delay();
    logic [15:0] cmds [3] = '{16'h0303, 16'h0300, 16'h0301};
    int          exp  [3] = '{96, 0, 32};
    for (int k = 0; k < 3; k++) begin
      int n;
      send_cmd(cmds[k]);
      n = 0;
      while (!cmd_ready && n < 1000) begin
        n++;
        @(negedge clock);
      end
      checks++;
      if (n !== exp[k]) begin
        errors++;
        $display("FAIL delay_%h: stall=%0d clocks required %0d", cmds[k], n, exp[k]);
      end
      $display("delay %h stalled %0d clocks", cmds[k], n);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp [$];
    logic [7:0] arg;
    for (int i = 0; i < DEPTH; i++) begin
      arg = 8'(i * 13 + 3);
      send_cmd({8'h00, arg});
      exp.push_back(~arg);
    end
    repeat (20) @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: cmd_ready=%b required 0", cmd_ready);
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== exp[0]) begin
      errors++;
      $display("FAIL full_head: valid=%b data=%h required 1 %h", resp_valid, resp_data, exp[0]);
    end
    pop_one();
    void'(exp.pop_front());
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_ready: cmd_ready=%b required 1", cmd_ready);
    end
    send_cmd(16'h0077);
    exp.push_back(8'h88);
    repeat (20) @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL refull_ready: cmd_ready=%b required 0", cmd_ready);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp[i]) begin
        errors++;
        $display("FAIL readback_%0d: valid=%b data=%h required 1 %h", i, resp_valid, resp_data, exp[i]);
      end
      $display("pop %0d data %h", i, resp_data);
      @(negedge clock);
    end
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL readback_empty: resp_valid=%b required 0", resp_valid);
    end
  endtask

  task automatic test_push_pop();
    int n;
    send_cmd(16'h0011);
    wait_resp("pp_first_wait");
    send_cmd(16'h0022);
    n = 0;
    while (!spi_data_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    // Pop the single stored entry in the same clock the new byte is pushed.
    pop_one();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 8'hDD) begin
      errors++;
      $display("FAIL push_pop_head: valid=%b data=%h required 1 dd", resp_valid, resp_data);
    end
    pop_one();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_empty: resp_valid=%b required 0", resp_valid);
    end
  endtask

  task automatic test_bad_opcode();
    int g0;
    send_cmd(16'h0100);
    g0 = go_count;
    send_cmd(16'h0755);
    checks++;
    if (err_opcode !== 1'b1) begin
      errors++;
      $display("FAIL badop_flag: err_opcode=%b required 1", err_opcode);
    end
    checks++;
    if (cs_active !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL badop_state: cs=%b ready=%b required 1 1", cs_active, cmd_ready);
    end
    checks++;
    if (go_count !== g0) begin
      errors++;
      $display("FAIL badop_go: go cycles=%0d required %0d", go_count, g0);
    end
    send_cmd(16'h0033);
    wait_resp("badop_resp_wait");
    checks++;
    if (err_opcode !== 1'b1 || resp_data !== 8'hCC) begin
      errors++;
      $display("FAIL badop_sticky: err_opcode=%b data=%h required 1 cc", err_opcode, resp_data);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send_cmd(16'h0044);
    n = 0;
    while (!spi_busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);                   // now in XFER_WAIT
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({spi_go, cs_active, resp_valid, err_opcode, cmd_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid: {go,cs,valid,eop,ready}=%b required 00000",
               {spi_go, cs_active, resp_valid, err_opcode, cmd_ready});
    end
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: ready=%b valid=%b required 1 0", cmd_ready, resp_valid);
    end
    $display("mid-transfer reset done at %0t", $time);
  endtask

  task automatic test_back_to_back();
    int g0;
    logic [7:0] exp [3] = '{8'hAA, 8'h99, 8'h88};
    g0 = go_count;
    send_cmd(16'h0055);
    send_cmd(16'h0066);
    send_cmd(16'h0077);
    repeat (10) @(negedge clock);
    checks++;
    if (go_count - g0 !== 3) begin
      errors++;
      $display("FAIL b2b_go: go cycles=%0d required 3", go_count - g0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp[i]) begin
        errors++;
        $display("FAIL b2b_data_%0d: valid=%b data=%h required 1 %h", i, resp_valid, resp_data, exp[i]);
      end
      pop_one();
    end
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    facade_en = 1'b0;
    send_cmd(16'h0099);
    n = 0;
    while (!err_timeout && n < 2 * TO) begin
      n++;
      @(negedge clock);
    end
    checks++;
    if (n !== TO) begin
      errors++;
      $display("FAIL timeout_clocks: took %0d clocks required %0d", n, TO);
    end
    checks++;
    if (resp_valid !== 1'b0 || spi_go !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_state: valid=%b go=%b ready=%b required 0 0 1", resp_valid, spi_go, cmd_ready);
    end
    facade_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_cs_xfer();
    test_delay();
    test_fifo_full();
    test_push_pop();
    test_bad_opcode();
    test_reset_mid();
    test_back_to_back();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
